// File: rtl/wb_uart_rx.sv
// wb_uart_rx: Wishbone-attached UART receiver (8N1, LSB first) feeding a small byte FIFO.
// Registers: RXDATA (pop on read), STATUS (sticky W1C error flags), DIVISOR (bit period - 1).
module wb_uart_rx #(
    parameter int unsigned WB_DATA_WIDTH   = 32,
    parameter int unsigned WB_ADDR_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     uart_rx_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     rx_irq_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // Line synchronizer and start-detect arming
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic [1:0]       r_sync_vld;
    logic             r_armed;
    logic             w_rx;

    // Receiver FSM and datapath
    state_e           r_state;
    state_e           w_state_next;
    logic [15:0]      r_divisor;
    logic [15:0]      w_div_eff;
    logic [15:0]      r_div_lat;
    logic [15:0]      r_period_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             w_start;
    logic             w_tick;
    logic             w_sample_bit;
    logic             w_stop_ok;
    logic             w_stop_bad;

    // FIFO
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_head;

    // Flags and bus
    logic             r_ovr;
    logic             r_fe;
    logic             w_set_ovr;
    logic             w_clr_ovr;
    logic             w_clr_fe;
    logic             w_req;
    logic [1:0]       w_addr;
    logic             r_ack;
    logic [WB_DATA_WIDTH-1:0] r_rdata;
    logic [WB_DATA_WIDTH-1:0] w_rdata;
    logic             w_unused;

    assign w_unused = ^{wb_addr_i[WB_ADDR_WIDTH-1:4], wb_addr_i[1:0],
                        wb_data_i[WB_DATA_WIDTH-1:16], wb_sel_i[3:2]};

    assign w_rx      = r_rx_sync;
    assign w_div_eff = (r_divisor < 16'd3) ? 16'd3 : r_divisor;
    assign w_addr    = wb_addr_i[3:2];
    assign w_req     = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_head    = r_mem[r_rd_ptr];
    assign w_pop     = w_req & ~wb_we_i & (w_addr == 2'd0) & ~w_empty;
    // A pop in the same cycle frees the slot the stop-bit push needs
    assign w_push    = w_stop_ok & (~w_full | w_pop);
    assign w_set_ovr = w_stop_ok & w_full & ~w_pop;
    assign w_clr_ovr = w_req & wb_we_i & (w_addr == 2'd1) & wb_sel_i[0] & wb_data_i[2];
    assign w_clr_fe  = w_req & wb_we_i & (w_addr == 2'd1) & wb_sel_i[0] & wb_data_i[3];

    assign wb_ack_o  = r_ack;
    assign wb_data_o = r_rdata;
    assign rx_irq_o  = ~w_empty;

    // Two-flop synchronizer; r_sync_vld marks when r_rx_sync holds a real line sample
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_sync_vld <= 2'b00;
        end else begin
            r_rx_meta  <= uart_rx_i;
            r_rx_sync  <= r_rx_meta;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
        end
    end

    // Arm start detection only after a genuine high sample while idle (break/reset recovery)
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_armed <= 1'b0;
        end else if (w_start) begin
            r_armed <= 1'b0;
        end else if ((r_state == StIdle) && r_sync_vld[1] && w_rx) begin
            r_armed <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (r_armed && !w_rx) w_state_next = StStart;
            StStart: if (w_tick) w_state_next = w_rx ? StIdle : StData;
            StData:  if (w_tick && (r_bit_cnt == 3'd7)) w_state_next = StStop;
            StStop:  if (w_tick) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs: decoded sampling events
    always_comb begin
        w_start      = 1'b0;
        w_tick       = (r_period_cnt == 16'd0);
        w_sample_bit = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            StIdle: begin
                w_start = r_armed & ~w_rx;
                w_tick  = 1'b0;
            end
            StData:  w_sample_bit = w_tick;
            StStop: begin
                w_stop_ok  = w_tick & w_rx;
                w_stop_bad = w_tick & ~w_rx;
            end
            default: ;
        endcase
    end

    // Period/bit counters and shift register; divisor is latched per frame
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_period_cnt <= '0;
            r_div_lat    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
        end else begin
            if (w_start) begin
                r_period_cnt <= {1'b0, w_div_eff[15:1]};
                r_div_lat    <= w_div_eff;
                r_bit_cnt    <= '0;
            end else if (r_state != StIdle) begin
                r_period_cnt <= w_tick ? r_div_lat : (r_period_cnt - 16'd1);
            end
            if (w_sample_bit) begin
                r_shift   <= {w_rx, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    // FIFO storage (no reset needed; occupancy gates every read)
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as its clear wins
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ovr <= 1'b0;
            r_fe  <= 1'b0;
        end else begin
            r_ovr <= (r_ovr & ~w_clr_ovr) | w_set_ovr;
            r_fe  <= (r_fe & ~w_clr_fe) | w_stop_bad;
        end
    end

    // DIVISOR register, byte-lane writes
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_divisor <= DEFAULT_DIVISOR;
        end else if (w_req && wb_we_i && (w_addr == 2'd2)) begin
            if (wb_sel_i[0]) r_divisor[7:0]  <= wb_data_i[7:0];
            if (wb_sel_i[1]) r_divisor[15:8] <= wb_data_i[15:8];
        end
    end

    // Read data mux
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            2'd0: begin
                w_rdata[7:0] = w_empty ? 8'h00 : w_head;
                w_rdata[31]  = w_empty;
            end
            2'd1:    w_rdata[3:0]  = {r_fe, r_ovr, w_full, ~w_empty};
            2'd2:    w_rdata[15:0] = r_divisor;
            default: ;
        endcase
    end

    // Single-cycle registered ack; read data only present alongside ack
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_req;
            r_rdata <= (w_req && !wb_we_i) ? w_rdata : '0;
        end
    end

endmodule

// File: tb/tb_wb_uart_rx.sv
// tb_wb_uart_rx: directed + randomized bench for wb_uart_rx with a queue-based reference model.
module tb_wb_uart_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rx;
    logic [31:0] wb_addr;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_cyc;
    logic        wb_ack;
    logic [31:0] wb_rdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0]  mq[$];
    logic        m_ovr;
    logic        m_fe;
    logic [15:0] m_div;

    always #5 clk = ~clk;

    wb_uart_rx dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .uart_rx_i (uart_rx),
        .wb_addr_i (wb_addr),
        .wb_data_i (wb_wdata),
        .wb_sel_i  (wb_sel),
        .wb_we_i   (wb_we),
        .wb_stb_i  (wb_stb),
        .wb_cyc_i  (wb_cyc),
        .wb_ack_o  (wb_ack),
        .wb_data_o (wb_rdata),
        .rx_irq_o  (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int eff_div(input logic [15:0] d);
        return (d < 16'd3) ? 3 : int'(d);
    endfunction

    function automatic logic [31:0] m_status();
        return {28'b0, m_fe, m_ovr, mq.size() == 4, mq.size() != 0};
    endfunction

    function automatic void m_frame(input logic [7:0] b, input logic stop);
        if (!stop) m_fe = 1'b1;
        else if (mq.size() < 4) mq.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    function automatic logic [31:0] m_pop();
        if (mq.size() == 0) return 32'h8000_0000;
        return {24'b0, mq.pop_front()};
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        m_div = 16'd433;
    endfunction

    // Serial frame: start bit, 8 data bits LSB first, stop bit, then idle gap
    task automatic send_frame(input logic [7:0] b, input logic stop, input int p);
        @(posedge clk); #1 uart_rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (p) @(posedge clk);
            #1 uart_rx = b[i];
        end
        repeat (p) @(posedge clk);
        #1 uart_rx = stop;
        repeat (p) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (2 * p) @(posedge clk);
        #1;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        send_frame(b, stop, eff_div(m_div) + 1);
        m_frame(b, stop);
    endtask

    task automatic wb_read(input int idx, output logic [31:0] d);
        int waited;
        wb_addr = 32'(idx) << 2;
        wb_we   = 1'b0;
        wb_sel  = 4'hF;
        wb_stb  = 1'b1;
        wb_cyc  = 1'b1;
        waited  = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!wb_ack && waited < 16);
        check("read_ack", {31'b0, wb_ack}, 32'd1);
        d      = wb_rdata;
        wb_stb = 1'b0;
        wb_cyc = 1'b0;
    endtask

    task automatic wb_write(input int idx, input logic [31:0] d, input logic [3:0] sel);
        int waited;
        wb_addr  = 32'(idx) << 2;
        wb_wdata = d;
        wb_sel   = sel;
        wb_we    = 1'b1;
        wb_stb   = 1'b1;
        wb_cyc   = 1'b1;
        waited   = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!wb_ack && waited < 16);
        check("write_ack", {31'b0, wb_ack}, 32'd1);
        wb_stb = 1'b0;
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
        if (idx == 2) begin
            if (sel[0]) m_div[7:0]  = d[7:0];
            if (sel[1]) m_div[15:8] = d[15:8];
        end else if (idx == 1 && sel[0]) begin
            if (d[2]) m_ovr = 1'b0;
            if (d[3]) m_fe  = 1'b0;
        end
    endtask

    task automatic rd_check(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(idx, d);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic        stop;
        int          acks;
        logic        prev_ack;
        int          off;
        int          e;

        uart_rx = 1'b1;
        wb_addr = '0; wb_wdata = '0; wb_sel = '0;
        wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
        rst_n = 1'b1;
        m_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", {31'b0, wb_ack}, 32'd0);
        check("reset_data", wb_rdata, 32'd0);
        check("reset_irq", {31'b0, irq}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rd_check("reset_status", 1, m_status());
        rd_check("reset_rxdata_empty", 0, m_pop());
        rd_check("reset_divisor", 2, {16'b0, m_div});

        // Basic reception at 10 clocks/bit
        wb_write(2, 32'd9, 4'hF);
        rd_check("div_readback", 2, {16'b0, m_div});
        rx_frame(8'hA5, 1'b1);
        rd_check("a5_status", 1, m_status());
        check("a5_irq", {31'b0, irq}, 32'd1);
        rd_check("a5_rxdata", 0, m_pop());
        rd_check("a5_status_after", 1, m_status());
        check("a5_irq_after", {31'b0, irq}, 32'd0);

        // Byte-lane writes and the unused register
        wb_write(2, 32'hABCD_1234, 4'b0010);
        rd_check("div_lane1", 2, {16'b0, m_div});
        wb_write(2, 32'h0000_0009, 4'b0011);
        rd_check("div_lanes", 2, {16'b0, m_div});
        wb_write(3, 32'hFFFF_FFFF, 4'hF);
        rd_check("reg3_zero", 3, 32'd0);

        // Held strobe: acks alternate, data zero whenever ack is low
        wb_addr = 32'd8; wb_we = 1'b0; wb_sel = 4'hF; wb_stb = 1'b1; wb_cyc = 1'b1;
        acks = 0; prev_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (wb_ack) acks++;
            check("no_b2b_ack", {31'b0, wb_ack & prev_ack}, 32'd0);
            check("ack_data", wb_rdata, wb_ack ? {16'b0, m_div} : 32'd0);
            prev_ack = wb_ack;
        end
        wb_stb = 1'b0; wb_cyc = 1'b0;
        check("ack_count", 32'(acks), 32'd3);

        // Overrun: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b1);
        rd_check("ovr_status", 1, m_status());
        for (int i = 0; i < 5; i++) rd_check("ovr_drain", 0, m_pop());
        wb_write(1, 32'h4, 4'h1);
        rd_check("ovr_cleared", 1, m_status());

        // Frame error with stop bit 0
        rx_frame(8'h3C, 1'b0);
        rd_check("fe_status", 1, m_status());
        rd_check("fe_empty", 0, m_pop());
        wb_write(1, 32'h8, 4'h1);
        rd_check("fe_cleared", 1, m_status());

        // Three-clock low glitch is rejected; a real frame follows cleanly
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        rd_check("glitch_status", 1, m_status());
        check("glitch_irq", {31'b0, irq}, 32'd0);
        b = 8'($urandom);
        rx_frame(b, 1'b1);
        rd_check("post_glitch_rx", 0, m_pop());

        // Full FIFO: pop lands in the same cycle as the stop-bit push
        for (int i = 0; i < 4; i++) rx_frame(8'($urandom), 1'b1);
        e   = eff_div(m_div);
        off = 4 + e / 2 + 9 * (e + 1);
        b   = 8'($urandom);
        fork
            send_frame(b, 1'b1, e + 1);
            begin
                repeat (off) @(posedge clk);
                #1;
                wb_read(0, d);
            end
        join
        check("simul_pop_head", d, m_pop());
        m_frame(b, 1'b1);
        rd_check("simul_status", 1, m_status());
        for (int i = 0; i < 4; i++) rd_check("simul_order", 0, m_pop());

        // Divisor write mid-frame only affects the next frame
        b = 8'($urandom);
        fork
            send_frame(b, 1'b1, eff_div(m_div) + 1);
            begin
                repeat (40) @(posedge clk);
                #1;
                wb_write(2, 32'd20, 4'h3);
            end
        join
        m_frame(b, 1'b1);
        rd_check("middiv_old", 0, m_pop());
        b = 8'($urandom);
        rx_frame(b, 1'b1);
        rd_check("middiv_new", 0, m_pop());

        // Randomized divisors (including sub-minimum values) and occasional bad stop bits
        for (int i = 0; i < 12; i++) begin
            wb_write(2, 32'($urandom_range(0, 24)), 4'h3);
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            rx_frame(b, stop);
            rd_check("rand_status", 1, m_status());
            rd_check("rand_rxdata", 0, m_pop());
            wb_write(1, 32'hC, 4'h1);
        end

        // Reset pulsed mid-frame (DATA bit 3, line low) with a byte already queued
        wb_write(2, 32'd9, 4'h3);
        rx_frame(8'h77, 1'b1);
        check("pre_reset_irq", {31'b0, irq}, 32'd1);
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (45) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_ack", {31'b0, wb_ack}, 32'd0);
        check("midrst_data", wb_rdata, 32'd0);
        check("midrst_irq", {31'b0, irq}, 32'd0);
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rd_check("midrst_status", 1, m_status());
        wb_write(2, 32'd9, 4'h3);
        rx_frame(8'h5A, 1'b1);
        rd_check("midrst_5a", 0, m_pop());
        rd_check("midrst_final_status", 1, m_status());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
